// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor with mtime, mtimecmp and msip behind a one-deep req/rsp bus.
// Optional CLINT_HI_LATCH_EN adds a shadow of mtime[63:32] captured on mtime[31:0] reads.
module clint_timer #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              timer_irq,
    output logic              msip_irq,
    output logic [63:0]       mtime_out
);
    localparam int unsigned       PRE_W     = 16;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] OFF_MSIP  = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] OFF_CMPLO = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] OFF_CMPHI = ADDR_W'(16'h4004);
    localparam logic [ADDR_W-1:0] OFF_MTLO  = ADDR_W'(16'hBFF8);
    localparam logic [ADDR_W-1:0] OFF_MTHI  = ADDR_W'(16'hBFFC);

    logic [PRE_W-1:0]  prescaler;
    logic [63:0]       mtime;
    logic [63:0]       mtime_nxt;
    logic [63:0]       mtimecmp;
    logic              msip;
    logic              tick;
    logic              accept;
    logic [ADDR_W-1:0] word_addr;
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       rd_data;
    logic [31:0]       rd_hi_val;

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_we;
    assign rd_en     = accept && !req_we;
    assign word_addr = req_addr & ~ADDR_W'(3);
    assign tick      = (prescaler == PRE_LAST);
    assign msip_irq  = msip;
    assign mtime_out = mtime;

`ifdef CLINT_HI_LATCH_EN
    logic [31:0] mtime_hi_shadow;

    // Shadow follows any mtime write, otherwise snapshots the high half on a low-half read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_hi_shadow <= '0;
        end else if (wr_en && (word_addr == OFF_MTLO || word_addr == OFF_MTHI)) begin
            mtime_hi_shadow <= mtime_nxt[63:32];
        end else if (rd_en && word_addr == OFF_MTLO) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end

    assign rd_hi_val = mtime_hi_shadow;
`else
    assign rd_hi_val = mtime[63:32];
`endif

    // Read mux sees register state before this cycle's updates.
    always_comb begin
        rd_data = '0;
        case (word_addr)
            OFF_MSIP:  rd_data = {31'd0, msip};
            OFF_CMPLO: rd_data = mtimecmp[31:0];
            OFF_CMPHI: rd_data = mtimecmp[63:32];
            OFF_MTLO:  rd_data = mtime[31:0];
            OFF_MTHI:  rd_data = rd_hi_val;
            default:   rd_data = '0;
        endcase
    end

    // A bus write to either mtime half wins over the tick in the same cycle.
    always_comb begin
        mtime_nxt = mtime;
        if (wr_en && word_addr == OFF_MTLO) begin
            mtime_nxt = {mtime[63:32], req_wdata};
        end else if (wr_en && word_addr == OFF_MTHI) begin
            mtime_nxt = {req_wdata, mtime[31:0]};
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            msip      <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
            mtime     <= mtime_nxt;
            if (wr_en && word_addr == OFF_CMPLO) mtimecmp[31:0]  <= req_wdata;
            if (wr_en && word_addr == OFF_CMPHI) mtimecmp[63:32] <= req_wdata;
            if (wr_en && word_addr == OFF_MSIP)  msip            <= req_wdata[0];
            timer_irq <= (mtime >= mtimecmp);
        end
    end

    // Response slot: loads on accept, holds until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= req_we ? 32'd0 : rd_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: two clint_timer instances (TICK_DIV 4 and 1) on one shared bus,
// compared against a cycle-level reference model with a response scoreboard.
`timescale 1ns/1ps
module tb_clint_timer;
    localparam int unsigned DIV_A = 4;
    localparam int unsigned DIV_B = 1;
    localparam logic [15:0] A_MSIP  = 16'h0000;
    localparam logic [15:0] A_CMPLO = 16'h4000;
    localparam logic [15:0] A_CMPHI = 16'h4004;
    localparam logic [15:0] A_MTLO  = 16'hBFF8;
    localparam logic [15:0] A_MTHI  = 16'hBFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b1;

    logic        req_ready_a, rsp_valid_a, timer_irq_a, msip_irq_a;
    logic [31:0] rsp_rdata_a;
    logic [63:0] mtime_a;
    logic        req_ready_b, rsp_valid_b, timer_irq_b, msip_irq_b;
    logic [31:0] rsp_rdata_b;
    logic [63:0] mtime_b;

    clint_timer #(.TICK_DIV(DIV_A), .ADDR_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
        .timer_irq(timer_irq_a), .msip_irq(msip_irq_a), .mtime_out(mtime_a)
    );

    clint_timer #(.TICK_DIV(DIV_B), .ADDR_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
        .timer_irq(timer_irq_b), .msip_irq(msip_irq_b), .mtime_out(mtime_b)
    );

    always #5 clk = ~clk;

    // Reference model state, index 0 = TICK_DIV 4, index 1 = TICK_DIV 1.
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp [2];
    logic [31:0] m_shadow [2];
    logic        m_msip [2];
    logic        m_irq [2];
    logic        m_rsp_v [2];
    logic [31:0] m_rsp_d [2];
    int unsigned cyc;
    logic        last_acc;
    int          last_wait;
    bit          rand_rr = 1'b0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_note(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mtime[d] = '0; m_cmp[d] = '1; m_shadow[d] = '0;
            m_msip[d] = 1'b0; m_irq[d] = 1'b0; m_rsp_v[d] = 1'b0; m_rsp_d[d] = '0;
        end
        cyc = 0;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [15:0] a);
        logic [15:0] w;
        w = a & 16'hFFFC;
        case (w)
            A_MSIP:  return {31'd0, m_msip[d]};
            A_CMPLO: return m_cmp[d][31:0];
            A_CMPHI: return m_cmp[d][63:32];
            A_MTLO:  return m_mtime[d][31:0];
`ifdef CLINT_HI_LATCH_EN
            A_MTHI:  return m_shadow[d];
`else
            A_MTHI:  return m_mtime[d][63:32];
`endif
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the architectural behaviour, using the inputs present at that edge.
    task automatic model_step(input int d, input int unsigned div);
        logic        acc, wr, tick, irq_next;
        logic [15:0] w;
        logic [31:0] rd;
        logic [63:0] old_t;
        acc   = req_valid && (!m_rsp_v[d] || rsp_ready);
        wr    = acc && req_we;
        w     = req_addr & 16'hFFFC;
        rd    = model_read(d, req_addr);
        old_t = m_mtime[d];
        tick  = ((cyc + 1) % div) == 0;
        irq_next = (old_t >= m_cmp[d]);
        if (wr && w == A_MTLO)      m_mtime[d] = {old_t[63:32], req_wdata};
        else if (wr && w == A_MTHI) m_mtime[d] = {req_wdata, old_t[31:0]};
        else if (tick)              m_mtime[d] = old_t + 64'd1;
        if (wr && (w == A_MTLO || w == A_MTHI)) m_shadow[d] = m_mtime[d][63:32];
        else if (acc && !req_we && w == A_MTLO) m_shadow[d] = old_t[63:32];
        if (wr && w == A_CMPLO) m_cmp[d][31:0]  = req_wdata;
        if (wr && w == A_CMPHI) m_cmp[d][63:32] = req_wdata;
        if (wr && w == A_MSIP)  m_msip[d] = req_wdata[0];
        m_irq[d] = irq_next;
        if (acc) begin
            m_rsp_v[d] = 1'b1;
            m_rsp_d[d] = req_we ? 32'd0 : rd;
            if (d == 0) exp_q0.push_back(m_rsp_d[d]);
            else        exp_q1.push_back(m_rsp_d[d]);
        end else if (rsp_ready) begin
            m_rsp_v[d] = 1'b0;
        end
        if (d == 1) last_acc = acc;
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        if (!rst) begin
            model_step(0, DIV_A);
            model_step(1, DIV_B);
            cyc++;
        end
        #1;
        if (rand_rr) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick_cycle();
    endtask

    task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        do begin
            tick_cycle();
            n++;
        end while (!last_acc && n < 100);
        if (!last_acc) fail_note("bus_accept_timeout");
        last_wait = n;
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready_a", req_ready_a, 1'b1);
        check("rst_rsp_valid_a", rsp_valid_a, 1'b0);
        check("rst_rsp_rdata_a", rsp_rdata_a, 32'd0);
        check("rst_timer_irq_a", timer_irq_a, 1'b0);
        check("rst_msip_irq_a", msip_irq_a, 1'b0);
        check("rst_mtime_a", mtime_a, 64'd0);
        check("rst_req_ready_b", req_ready_b, 1'b1);
        check("rst_rsp_valid_b", rsp_valid_b, 1'b0);
        check("rst_timer_irq_b", timer_irq_b, 1'b0);
        check("rst_mtime_b", mtime_b, 64'd0);
    endtask

    // Asynchronous reset landing mid-cycle; any outstanding response is dropped.
    task automatic do_reset();
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic mon_inst(input int d, input logic rv, input logic rqr, input logic [31:0] rdat,
                            input logic ti, input logic mi, input logic [63:0] mt);
        check($sformatf("rsp_valid_%0d", d), rv, m_rsp_v[d]);
        check($sformatf("req_ready_%0d", d), rqr, !m_rsp_v[d] || rsp_ready);
        check($sformatf("timer_irq_%0d", d), ti, m_irq[d]);
        check($sformatf("msip_irq_%0d", d), mi, m_msip[d]);
        check($sformatf("mtime_%0d", d), mt, m_mtime[d]);
        if (m_rsp_v[d]) check($sformatf("rsp_hold_%0d", d), rdat, m_rsp_d[d]);
        if (rv === 1'b1 && rsp_ready) begin
            if (d == 0) begin
                if (exp_q0.size() == 0) fail_note("rsp_unexpected_0");
                else check("sb_rdata_0", rdat, exp_q0.pop_front());
            end else begin
                if (exp_q1.size() == 0) fail_note("rsp_unexpected_1");
                else check("sb_rdata_1", rdat, exp_q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_inst(0, rsp_valid_a, req_ready_a, rsp_rdata_a, timer_irq_a, msip_irq_a, mtime_a);
            mon_inst(1, rsp_valid_b, req_ready_b, rsp_rdata_b, timer_irq_b, msip_irq_b, mtime_b);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] addr_tab [5];
        logic [15:0] a;
        logic [31:0] dat;
        addr_tab[0] = A_MSIP; addr_tab[1] = A_CMPLO; addr_tab[2] = A_CMPHI;
        addr_tab[3] = A_MTLO; addr_tab[4] = A_MTHI;

        #1 rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // 40 clocks after reset: TICK_DIV 4 reads 10, TICK_DIV 1 reads 40.
        idle(40);
        bus(1'b0, A_MTLO, 32'd0);
        check("div4_after_40", rsp_rdata_a, 32'd10);
        check("div1_after_40", rsp_rdata_b, 32'd40);

        // Timer interrupt at mtime == 20, then cleared by raising mtimecmp.
        bus(1'b1, A_CMPLO, 32'd20);
        bus(1'b1, A_CMPHI, 32'd0);
        bus(1'b1, A_MTLO, 32'd0);
        bus(1'b1, A_MTHI, 32'd0);
        n = 0;
        while (mtime_b != 64'd20 && n < 200) begin
            tick_cycle();
            n++;
        end
        if (mtime_b != 64'd20) fail_note("wait_mtime_20");
        check("irq_before_edge", timer_irq_b, 1'b0);
        tick_cycle();
        check("irq_rise", timer_irq_b, 1'b1);
        idle(4);
        bus(1'b1, A_CMPLO, 32'hFFFF_FFFF);
        check("irq_hold_on_cmp_write", timer_irq_b, 1'b1);
        tick_cycle();
        check("irq_fall", timer_irq_b, 1'b0);

        // Carry from low to high half, then full 64-bit wrap.
        bus(1'b1, A_MTHI, 32'd0);
        bus(1'b1, A_MTLO, 32'hFFFF_FFFF);
        check("mtime_write_no_tick", mtime_b, 64'h0000_0000_FFFF_FFFF);
        idle(2);
        check("mtime_carry", mtime_b, 64'h0000_0001_0000_0001);
        bus(1'b1, A_MTLO, 32'hFFFF_FFFF);
        bus(1'b1, A_MTHI, 32'hFFFF_FFFF);
        check("mtime_all_ones", mtime_b, 64'hFFFF_FFFF_FFFF_FFFF);
        tick_cycle();
        check("mtime_wrap", mtime_b, 64'd0);

        // MSIP writes only bit 0.
        bus(1'b1, A_MSIP, 32'hFFFF_FFFF);
        check("msip_set", msip_irq_b, 1'b1);
        bus(1'b0, A_MSIP, 32'd0);
        check("msip_read", rsp_rdata_b, 32'd1);
        bus(1'b1, A_MSIP, 32'd0);
        check("msip_clear", msip_irq_b, 1'b0);

        // Back-pressure: response held while rsp_ready is low.
        idle(1);
        rsp_ready = 1'b0;
        bus(1'b0, A_CMPLO, 32'd0);
        repeat (5) begin
            tick_cycle();
            check("bp_req_ready", req_ready_b, 1'b0);
            check("bp_rsp_valid", rsp_valid_b, 1'b1);
            check("bp_rsp_rdata", rsp_rdata_b, 32'hFFFF_FFFF);
        end
        rsp_ready = 1'b1;
        bus(1'b0, A_CMPLO, 32'd0);
        check("b2b_wait_1", last_wait, 1);
        bus(1'b0, 16'h1234, 32'd0);
        check("b2b_wait_2", last_wait, 1);
        check("unmapped_read", rsp_rdata_b, 32'd0);

        // Tear-free high-half read around a carry.
        bus(1'b1, A_MTHI, 32'd0);
        bus(1'b1, A_MTLO, 32'hFFFF_FFFE);
        bus(1'b0, A_MTLO, 32'd0);
        check("shadow_lo_read", rsp_rdata_b, 32'hFFFF_FFFE);
        idle(3);
        bus(1'b0, A_MTHI, 32'd0);
`ifdef CLINT_HI_LATCH_EN
        check("shadow_hi_read", rsp_rdata_b, 32'd0);
`else
        check("live_hi_read", rsp_rdata_b, 32'd1);
`endif

        // Randomized traffic with back-pressure and occasional mid-transaction reset.
        rand_rr = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) a = 16'($urandom);
            else a = addr_tab[$urandom_range(0, 4)] | 16'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       dat = 32'd0;
                1:       dat = 32'($urandom_range(0, 3000));
                default: dat = $urandom;
            endcase
            bus(1'($urandom_range(0, 1)), a, dat);
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        rand_rr = 1'b0;
        rsp_ready = 1'b1;
        idle(3);
        check("sb_drain", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Memory-mapped core-local interruptor. Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and the MSIP bit.
- Drives timer_irq and msip_irq into the CSR file's interrupt inputs.
- Exports mtime so the CSR time/timeh registers read real time.
- Sits on the SoC data bus between the core's load/store unit and the CSR file.

Parameters:
- TICK_DIV, 1: clk cycles per mtime increment; legal range 1..65535.
- ADDR_W, 16: width of the byte address offset within the CLINT window.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid  in  1  bus request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte offset; bits [1:0] ignored
- req_wdata  in  32  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  read data; 0 for writes
- timer_irq  out  1  MTIP, level
- msip_irq  out  1  MSIP, level
- mtime_out  out  64  current mtime

Behaviour:
- Register map (word offsets):
  - 0x0000 msip: only bit 0 is writable; other bits read 0.
  - 0x4000 mtimecmp[31:0]
  - 0x4004 mtimecmp[63:32]
  - 0xBFF8 mtime[31:0]
  - 0xBFFC mtime[63:32]
  - Any other offset: reads return 0, writes are ignored. No error response exists.
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0.
  - timer_irq = 0, msip_irq = 0, rsp_valid = 0, rsp_rdata = 0, req_ready = 1.
- Handshake:
  - Single outstanding transaction.
  - req_ready = !rsp_valid || rsp_ready.
  - A request accepted in cycle N produces rsp_valid in cycle N+1.
  - rsp_valid and rsp_rdata hold until rsp_ready. Back-to-back transactions run at one per cycle when rsp_ready stays high.
- Read data is sampled in the accept cycle and reflects register state before any update in that cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1. Reaching TICK_DIV-1 wraps it to 0 and generates a tick.
  - A tick increments mtime by 1, wrapping 64'hFFFF_FFFF_FFFF_FFFF to 0.
  - With TICK_DIV=1 every cycle is a tick.
- Write to mtime low or high half:
  - The addressed half takes req_wdata; the other half keeps its current value.
  - The tick in that cycle is suppressed; the prescaler keeps counting.
- Write to mtimecmp takes effect the next cycle.
- timer_irq is registered: timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values.
  - It asserts one cycle after the condition becomes true.
  - It deasserts one cycle after mtimecmp is raised above mtime.
- msip_irq = msip register bit. A write to msip is visible on msip_irq the next cycle.
- Simultaneous events: a bus write and a tick in the same cycle resolve as above. Writes to mtimecmp and msip never interact with the tick.
- Reset asserted mid-transaction: everything returns to reset values asynchronously and any pending response is discarded. After reset releases, the first cycle can accept a request.

Optional Feature:
- Macro: CLINT_HI_LATCH_EN.
- Defined:
  - Reading mtime[31:0] also latches mtime[63:32] into a shadow register.
  - A following read of mtime[63:32] returns the shadow, giving tear-free 64-bit reads.
  - Any write to mtime refreshes the shadow with the new high half.
  - The shadow resets to 0.
- Undefined: no shadow register; reads of mtime[63:32] return the live value.

Test Plan:
- Reset with TICK_DIV=4 -> timer_irq=0, msip_irq=0, req_ready=1. After 40 clks a read of 0xBFF8 returns 10.
- TICK_DIV=1: write mtimecmp low=20, high=0, mtime=0 -> timer_irq rises exactly one cycle after mtime reaches 20. Writing mtimecmp low=0xFFFF_FFFF then drops it one cycle later.
- Write mtime low=0xFFFF_FFFF, high=0 with TICK_DIV=1 -> after 2 ticks low=1, high=1. Write mtime=64'hFFFF_FFFF_FFFF_FFFF -> wraps to 0 on the next tick.
- Write 0x0000=0xFFFF_FFFF -> msip_irq=1 next cycle and read returns 1. Write 0 -> msip_irq=0.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable, req_ready=0. Then rsp_ready=1 with back-to-back reads of 0x4000 and 0x1234 -> responses in consecutive cycles; 0x1234 returns 0.
- CLINT_HI_LATCH_EN, TICK_DIV=1, mtime=0x0000_0000_FFFF_FFFE: read low, wait 3 cycles, read high -> returns 0. With the macro undefined the same sequence returns 1.
